// File: rtl/sys_defs_pkg.sv
// sys_defs: shared types and constants for the out-of-order core.
//   INST              decoded instruction word
//   MAPTABLE_PACKET   rename tag plus ready bit from the register map table
//   RS_ENTRY          one reservation station slot
//   RS_ISSUE_PACKET   payload handed to the execute stage on issue
//   RS_SIZE_DEFAULT   default reservation station depth
package sys_defs;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int ROB_TAG_LEN     = 5;
   localparam int RS_SIZE_DEFAULT = 8;

   typedef logic [31:0]            INST;
   typedef logic [ROB_TAG_LEN-1:0] ROB_TAG;

   typedef struct packed {
      ROB_TAG rob_tag;
      logic   rob_tag_ready;
   } MAPTABLE_PACKET;

   typedef struct packed {
      logic        valid;
      INST         inst;
      logic [31:0] pc;
      ROB_TAG      rob_tag;
      ROB_TAG      rs1_tag;
      logic        rs1_ready;
      ROB_TAG      rs2_tag;
      logic        rs2_ready;
   } RS_ENTRY;

   typedef struct packed {
      INST         inst;
      logic [31:0] pc;
      ROB_TAG      rob_tag;
      ROB_TAG      rs1_tag;
      ROB_TAG      rs2_tag;
   } RS_ISSUE_PACKET;

   // Tag 0 means "value in the register file", so it never matches a broadcast.
   function automatic logic tag_hit(input logic wb_valid, input ROB_TAG wb_tag,
                                    input ROB_TAG tag);
      return wb_valid && (wb_tag != '0) && (wb_tag == tag);
   endfunction

endpackage

// File: rtl/reservation_station_select.sv
// rs_select: priority picker.
//   req    in   N     candidate vector
//   age    in   NxN   age[j][i]=1 means entry j is older than entry i
//   valid  out  1     some request is set
//   index  out  IDX   chosen entry
// Picks the lowest index among requests with no older requester; with age tied
// to zero this degenerates to a plain lowest-index priority encoder.
module rs_select #(
   parameter int N   = 8,
   parameter int IDX = $clog2(N)
) (
   input  logic [N-1:0]        req,
   input  logic [N-1:0][N-1:0] age,
   output logic                valid,
   output logic [IDX-1:0]      index
);

   logic [N-1:0] eligible;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < N; i++) begin
         eligible[i] = req[i];
         for (int j = 0; j < N; j++) begin
            if (req[j] && age[j][i]) eligible[i] = 1'b0;
         end
      end
      valid = |req;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i]) index = IDX'(i);
      end
   end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue buffer between dispatch and execute.
//   clock, reset                 clock; synchronous active-high reset
//   dispatch_*, uses_rs1/2       new instruction and its operand rename packets
//   full, count                  registered occupancy
//   wb_valid, wb_rob_tag         writeback broadcast used for wakeup
//   issue_ready/valid/packet     one issue per cycle to the execute stage
//   flush                        squash every entry at the next edge
// Build option: define RS_OLDEST_FIRST_EN to select the oldest ready entry via
// an age matrix; otherwise the lowest-index ready entry is selected.
module reservation_station
   import sys_defs::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEFAULT,
   parameter int IDX_LEN = $clog2(RS_SIZE)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   dispatch_valid,
   input  INST                    dispatch_inst,
   input  logic [31:0]            dispatch_pc,
   input  logic [ROB_TAG_LEN-1:0] dispatch_rob_tag,
   input  MAPTABLE_PACKET         dispatch_rs1,
   input  MAPTABLE_PACKET         dispatch_rs2,
   input  logic                   uses_rs1,
   input  logic                   uses_rs2,
   output logic                   full,
   output logic [IDX_LEN:0]       count,
   input  logic                   wb_valid,
   input  logic [ROB_TAG_LEN-1:0] wb_rob_tag,
   input  logic                   issue_ready,
   output logic                   issue_valid,
   output RS_ISSUE_PACKET         issue_packet,
   input  logic                   flush
);

   RS_ENTRY entries_q [RS_SIZE];
   RS_ENTRY entries_d [RS_SIZE];

   logic [RS_SIZE-1:0]              valid_vec, ready_vec, free_vec;
   logic [RS_SIZE-1:0][RS_SIZE-1:0] age;
   logic [IDX_LEN-1:0]              issue_idx, alloc_idx;
   logic                            free_valid, alloc_fire, issue_fire;
   logic [IDX_LEN:0]                count_q, count_d;
   logic                            full_q;

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         valid_vec[i] = entries_q[i].valid;
         ready_vec[i] = entries_q[i].valid && entries_q[i].rs1_ready && entries_q[i].rs2_ready;
      end
      free_vec = ~valid_vec;
   end

   rs_select #(.N(RS_SIZE), .IDX(IDX_LEN)) u_issue_select (
      .req   (ready_vec),
      .age   (age),
      .valid (issue_valid),
      .index (issue_idx)
   );

   rs_select #(.N(RS_SIZE), .IDX(IDX_LEN)) u_alloc_select (
      .req   (free_vec),
      .age   ('0),
      .valid (free_valid),
      .index (alloc_idx)
   );

   // Slots freed by this cycle's issue are not reusable until the next cycle.
   assign alloc_fire = dispatch_valid && !full_q && free_valid && !flush;
   assign issue_fire = issue_valid && issue_ready;

   always_comb begin
      issue_packet = '0;
      if (issue_valid) begin
         issue_packet.inst    = entries_q[issue_idx].inst;
         issue_packet.pc      = entries_q[issue_idx].pc;
         issue_packet.rob_tag = entries_q[issue_idx].rob_tag;
         issue_packet.rs1_tag = entries_q[issue_idx].rs1_tag;
         issue_packet.rs2_tag = entries_q[issue_idx].rs2_tag;
      end
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].valid) begin
            if (tag_hit(wb_valid, wb_rob_tag, entries_q[i].rs1_tag)) entries_d[i].rs1_ready = TRUE;
            if (tag_hit(wb_valid, wb_rob_tag, entries_q[i].rs2_tag)) entries_d[i].rs2_ready = TRUE;
         end
      end
      if (issue_fire) entries_d[issue_idx].valid = FALSE;
      if (alloc_fire) begin
         entries_d[alloc_idx].valid     = TRUE;
         entries_d[alloc_idx].inst      = dispatch_inst;
         entries_d[alloc_idx].pc        = dispatch_pc;
         entries_d[alloc_idx].rob_tag   = dispatch_rob_tag;
         entries_d[alloc_idx].rs1_tag   = dispatch_rs1.rob_tag;
         entries_d[alloc_idx].rs2_tag   = dispatch_rs2.rob_tag;
         entries_d[alloc_idx].rs1_ready = dispatch_rs1.rob_tag_ready || !uses_rs1
                                          || (dispatch_rs1.rob_tag == '0)
                                          || tag_hit(wb_valid, wb_rob_tag, dispatch_rs1.rob_tag);
         entries_d[alloc_idx].rs2_ready = dispatch_rs2.rob_tag_ready || !uses_rs2
                                          || (dispatch_rs2.rob_tag == '0)
                                          || tag_hit(wb_valid, wb_rob_tag, dispatch_rs2.rob_tag);
      end
      if (flush) begin
         for (int i = 0; i < RS_SIZE; i++) entries_d[i].valid = FALSE;
      end
      count_d = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         count_d = count_d + (IDX_LEN + 1)'(entries_d[i].valid);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
         count_q <= '0;
         full_q  <= FALSE;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= entries_d[i];
         count_q <= count_d;
         full_q  <= (count_d == (IDX_LEN + 1)'(RS_SIZE));
      end
   end

   assign count = count_q;
   assign full  = full_q;

`ifdef RS_OLDEST_FIRST_EN
   // age_q[r][c]=1: entry r was allocated before entry c. Rows of invalid
   // entries may hold stale bits; the picker masks them with the request vector.
   logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         age_q <= '0;
      end else if (alloc_fire) begin
         age_q[alloc_idx] <= '0;
         for (int r = 0; r < RS_SIZE; r++) begin
            if ((r != int'(alloc_idx)) && valid_vec[r]) age_q[r][alloc_idx] <= 1'b1;
         end
      end
   end

   assign age = age_q;
`else
   assign age = '0;
`endif

endmodule

// File: doc/reservation_station.md
# reservation_station

Out-of-order issue buffer between dispatch and the functional units. Each dispatched instruction arrives with its operand rename packets (ROB tag + ready bit) read from the register map table. Entries wait in the buffer and snoop the writeback broadcast until both operands are ready. A select stage then issues one ready instruction per cycle to the execute stage.

## Interface
Parameters:
- `RS_SIZE`, 8: number of entries; power of two, ≥ 2.
- `IDX_LEN`, `$clog2(RS_SIZE)`: entry index width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `dispatch_valid`  in  1  dispatch request this cycle.
- `dispatch_inst`  in  INST  decoded instruction.
- `dispatch_pc`  in  32  instruction PC.
- `dispatch_rob_tag`  in  `ROB_TAG_LEN`  destination ROB entry.
- `dispatch_rs1`, `dispatch_rs2`  in  MAPTABLE_PACKET  operand tag/ready from the map table.
- `uses_rs1`, `uses_rs2`  in  1  operand actually read by the instruction.
- `full`  out  1  no free entry; dispatch must not be asserted.
- `count`  out  IDX_LEN+1  number of valid entries.
- `wb_valid`  in  1  writeback broadcast valid.
- `wb_rob_tag`  in  `ROB_TAG_LEN`  broadcast ROB tag.
- `issue_ready`  in  1  execute stage accepts an issue this cycle.
- `issue_valid`  out  1  an entry is selected.
- `issue_packet`  out  RS_ISSUE_PACKET  inst, pc, rob_tag, rs1_tag, rs2_tag of the selected entry.
- `flush`  in  1  branch misprediction squash.

## Operation
- ROB tag 0 is reserved and means "value is in the architectural register file". An operand with tag 0, or with `uses_rsN`=0, is ready at capture.
- Allocation: on `dispatch_valid && !full && !flush`, write the lowest-index free entry.
  - Operand ready bit = packet `rob_tag_ready`, OR tag==0, OR !uses, OR (`wb_valid` && `wb_rob_tag`==tag).
  - The last term captures a same-cycle broadcast.
- Wakeup: every valid entry whose not-ready operand tag equals `wb_rob_tag` while `wb_valid` sets that ready bit at the next edge.
  - Both operands may wake on the same broadcast.
  - `wb_rob_tag`==0 wakes nothing.
- Select: among valid entries with both operands ready, pick one. The pick is combinational from registered state.
  - `issue_valid`=1 whenever a candidate exists.
  - The entry is freed at the edge where `issue_valid && issue_ready`.
- Flush: all entries are invalidated at the next edge. Dispatch, wakeup and issue dequeue in that cycle are discarded.
  - `issue_valid` is still driven combinationally during the flush cycle; the execute stage ignores it.
- Dispatch while `full` is illegal. The block ignores it and a bench assertion fires.

## Timing
- Reset: all entries invalid; `full`=0, `count`=0, `issue_valid`=0, `issue_packet`=0.
- Dispatch → earliest issue: 1 cycle (entry visible the cycle after the dispatch edge, if its operands are ready).
- Wakeup → earliest issue: 1 cycle after the `wb_valid` cycle.
- `full` and `count` are registered and reflect state after the last edge.
  - A same-cycle issue does not free a slot for a dispatch in that cycle; there is no bypass.
- Simultaneous dispatch and issue (not full): both take effect; `count` is unchanged.
- Reset mid-operation overrides flush, dispatch and wakeup.

## Configuration
- `RS_OLDEST_FIRST_EN` defined: select picks the oldest ready entry.
  - Age is kept in an RS_SIZE×RS_SIZE age matrix.
  - On allocation, the new row is cleared and the new column is set in every other valid row.
- Not defined: select picks the lowest-index ready entry and the age matrix is not built.
- Allocation and flush behaviour are identical in both modes.

## Structure
- Shared package (`sys_defs`): `RS_ISSUE_PACKET`, `RS_ENTRY` (valid, inst, pc, rob_tag, rs1/rs2 tag + ready), `RS_SIZE` default constant.
  - Existing INST, MAPTABLE_PACKET, `ROB_TAG_LEN`, `TRUE`/`FALSE` are reused.
- Sub-module `rs_select`: parametric priority picker taking a ready vector and the optional age matrix, returning a valid bit and an index.
  - The same picker is used for free-slot allocation with the age input tied off.

## Test plan
- Dispatch add with rs1 tag 0 and rs2 tag 0 at cycle 0 → `issue_valid`=1 at cycle 1 with rob_tag matching; `count` returns to 0 after `issue_ready`.
- Dispatch with rs1 tag 3 not ready; `wb_valid` tag 3 at cycle 4 → no issue through cycle 4; issue at cycle 5.
- Dispatch with rs2 tag 5 not ready while `wb_valid` tag 5 in the same cycle → entry captured ready; issues the next cycle.
- Fill 8 entries, all blocked on tag 7 → `full`=1, `count`=8. Broadcast tag 7 → 8 consecutive issues with `issue_ready`=1. With `RS_OLDEST_FIRST_EN`, issue order equals dispatch order.
- Flush with 4 waiting entries plus a dispatch in the same cycle → `count`=0, `issue_valid`=0 next cycle.
- Hold `issue_ready`=0 for 3 cycles with one ready entry → `issue_valid` stays 1 with a stable packet; the entry is freed only at the accepting edge.
